// File: rtl/mips_pkg.sv
// Shared definitions for the fetch/decode boundary: opcodes, instruction field
// positions, IF/ID control state encoding and register-use decode helpers.
package mips_pkg;

    localparam logic [4:0] OP_NOP     = 5'h00;
    localparam logic [4:0] OP_R_FIRST = 5'h01;
    localparam logic [4:0] OP_R_LAST  = 5'h07;
    localparam logic [4:0] OP_I_FIRST = 5'h08;
    localparam logic [4:0] OP_I_LAST  = 5'h0F;
    localparam logic [4:0] OP_LD      = 5'h10;
    localparam logic [4:0] OP_ST      = 5'h11;
    localparam logic [4:0] OP_JMP     = 5'h18;
    localparam logic [4:0] OP_HALT    = 5'h1F;

    // rs2 and imm deliberately overlap: R/ST use rs2, I/LD/JMP use imm.
    localparam int OP_MSB  = 23;
    localparam int OP_LSB  = 19;
    localparam int RD_MSB  = 18;
    localparam int RD_LSB  = 14;
    localparam int RS1_MSB = 13;
    localparam int RS1_LSB = 9;
    localparam int RS2_MSB = 8;
    localparam int RS2_LSB = 4;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    localparam logic [1:0] ST_BOOT   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_R,
        CLS_I,
        CLS_LD,
        CLS_ST,
        CLS_JMP,
        CLS_HALT
    } ins_class_t;

    function automatic ins_class_t classify(input logic [4:0] op);
        ins_class_t cls;
        if (op >= OP_R_FIRST && op <= OP_R_LAST)
            cls = CLS_R;
        else if (op >= OP_I_FIRST && op <= OP_I_LAST)
            cls = CLS_I;
        else if (op == OP_LD)
            cls = CLS_LD;
        else if (op == OP_ST)
            cls = CLS_ST;
        else if (op == OP_JMP)
            cls = CLS_JMP;
        else if (op == OP_HALT)
            cls = CLS_HALT;
        else
            cls = CLS_NOP;
        return cls;
    endfunction

    function automatic logic reads_rs1(input logic [4:0] op);
        ins_class_t cls;
        cls = classify(op);
        return (cls == CLS_R) || (cls == CLS_I) || (cls == CLS_LD) || (cls == CLS_ST);
    endfunction

    function automatic logic reads_rs2(input logic [4:0] op);
        ins_class_t cls;
        cls = classify(op);
        return (cls == CLS_R) || (cls == CLS_ST);
    endfunction

endpackage

// File: rtl/ifid_decode.sv
// Combinational field split of the instruction held in IF/ID, plus the class
// and source-register-use flags the hazard logic needs.
module ifid_decode #(
    parameter int IW = 24
) (
    input  logic [IW-1:0] ins,
    output logic [4:0]    opcode,
    output logic [4:0]    rd,
    output logic [4:0]    rs1,
    output logic [4:0]    rs2,
    output logic [7:0]    imm,
    output logic          is_jmp,
    output logic          is_halt,
    output logic          uses_rs1,
    output logic          uses_rs2
);
    import mips_pkg::*;

    ins_class_t cls;

    assign opcode = ins[OP_MSB:OP_LSB];
    assign rd     = ins[RD_MSB:RD_LSB];
    assign rs1    = ins[RS1_MSB:RS1_LSB];
    assign rs2    = ins[RS2_MSB:RS2_LSB];
    assign imm    = ins[IMM_MSB:IMM_LSB];

    assign cls      = classify(opcode);
    assign is_jmp   = (cls == CLS_JMP);
    assign is_halt  = (cls == CLS_HALT);
    assign uses_rs1 = reads_rs1(opcode);
    assign uses_rs2 = reads_rs2(opcode);

endmodule

// File: rtl/ifid_hazard_unit.sv
// IF/ID register, load-use / JMP / HALT / backpressure control and ID/EX register.
// Define IFID_PERF_CNT_EN to build the saturating stall/flush performance counters.
module ifid_hazard_unit #(
    parameter int IW = 24,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [IW-1:0] ins,
    input  logic [AW-1:0] Current_Address,
    input  logic          ex_stall,
    output logic          Stall,
    output logic          Stall_pm,
    output logic          pc_mux_sel,
    output logic [AW-1:0] jmp_loc,
    output logic          ex_valid,
    output logic [4:0]    ex_opcode,
    output logic [4:0]    ex_rd,
    output logic [4:0]    ex_rs1,
    output logic [4:0]    ex_rs2,
    output logic [7:0]    ex_imm,
    output logic [AW-1:0] ex_pc,
    output logic          halted,
    output logic [15:0]   stall_cnt,
    output logic [15:0]   flush_cnt
);
    import mips_pkg::*;

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] id_ins_q;
    logic [AW-1:0] id_pc_q;
    logic          id_valid_q;
    logic [AW-1:0] fetch_pc_q;

    logic [4:0] dec_opcode, dec_rd, dec_rs1, dec_rs2;
    logic [7:0] dec_imm;
    logic       dec_is_jmp, dec_is_halt, dec_uses_rs1, dec_uses_rs2;

    logic load_use, take_jmp;
    logic hold_fetch, redirect;
    logic ifid_load, ifid_valid_d;
    logic ex_load, ex_bubble;

    ifid_decode #(.IW(IW)) u_decode (
        .ins      (id_ins_q),
        .opcode   (dec_opcode),
        .rd       (dec_rd),
        .rs1      (dec_rs1),
        .rs2      (dec_rs2),
        .imm      (dec_imm),
        .is_jmp   (dec_is_jmp),
        .is_halt  (dec_is_halt),
        .uses_rs1 (dec_uses_rs1),
        .uses_rs2 (dec_uses_rs2)
    );

    assign load_use = ex_valid && (ex_opcode == OP_LD) && (ex_rd != 5'd0) && id_valid_q &&
                      ((dec_uses_rs1 && (dec_rs1 == ex_rd)) ||
                       (dec_uses_rs2 && (dec_rs2 == ex_rd)));
    assign take_jmp = id_valid_q && dec_is_jmp;

    // Backpressure outranks load-use, which outranks a JMP redirect, so a
    // pending JMP simply waits in ID until the pipe is free to move.
    always_comb begin
        state_d      = state_q;
        hold_fetch   = 1'b0;
        redirect     = 1'b0;
        ifid_load    = 1'b0;
        ifid_valid_d = 1'b0;
        ex_load      = 1'b0;
        ex_bubble    = 1'b0;
        case (state_q)
            ST_BOOT: begin
                state_d   = ST_RUN;
                ifid_load = 1'b1;
                ex_bubble = 1'b1;
            end
            ST_RUN: begin
                if (ex_stall) begin
                    hold_fetch = 1'b1;
                end else if (load_use) begin
                    hold_fetch = 1'b1;
                    ex_bubble  = 1'b1;
                end else if (take_jmp) begin
                    redirect  = 1'b1;
                    ifid_load = 1'b1;
                    ex_bubble = 1'b1;
                end else begin
                    ifid_load    = 1'b1;
                    ifid_valid_d = 1'b1;
                    ex_load      = 1'b1;
                    if (id_valid_q && dec_is_halt) begin
                        state_d   = ST_HALTED;
                        ex_load   = 1'b0;
                        ex_bubble = 1'b1;
                    end
                end
            end
            ST_HALTED: begin
                hold_fetch = 1'b1;
                ex_bubble  = 1'b1;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    assign Stall      = hold_fetch && !reset;
    assign Stall_pm   = hold_fetch && !reset;
    assign pc_mux_sel = redirect && !reset;
    assign jmp_loc    = pc_mux_sel ? AW'(dec_imm) : '0;
    assign halted     = (state_q == ST_HALTED);

    // fetch_pc_q names the address whose instruction is on ins this cycle, so
    // it freezes whenever fetch is told to hold its output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_BOOT;
            fetch_pc_q <= '0;
            id_ins_q   <= '0;
            id_pc_q    <= '0;
            id_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (!hold_fetch)
                fetch_pc_q <= Current_Address;
            if (ifid_load) begin
                id_ins_q   <= ins;
                id_pc_q    <= fetch_pc_q;
                id_valid_q <= ifid_valid_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid  <= 1'b0;
            ex_opcode <= '0;
            ex_rd     <= '0;
            ex_rs1    <= '0;
            ex_rs2    <= '0;
            ex_imm    <= '0;
            ex_pc     <= '0;
        end else if (ex_load) begin
            ex_valid  <= id_valid_q;
            ex_opcode <= dec_opcode;
            ex_rd     <= dec_rd;
            ex_rs1    <= dec_rs1;
            ex_rs2    <= dec_rs2;
            ex_imm    <= dec_imm;
            ex_pc     <= id_pc_q;
        end else if (ex_bubble) begin
            ex_valid <= 1'b0;
        end
    end

`ifdef IFID_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= 16'h0000;
            flush_cnt <= 16'h0000;
        end else begin
            if ((state_q == ST_RUN) && hold_fetch && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;
            if (redirect && (flush_cnt != 16'hFFFF))
                flush_cnt <= flush_cnt + 16'd1;
        end
    end
`else
    assign stall_cnt = 16'h0000;
    assign flush_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_ifid_hazard_unit.sv
// Bench for ifid_hazard_unit: a fetch-side environment model, an ISA-level
// expected stream of instructions entering EX, and directed cycle checks.
module tb_ifid_hazard_unit;
    localparam int IW = 24;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [IW-1:0] ins;
    logic [AW-1:0] cur_addr;
    logic          ex_stall;
    logic          Stall, Stall_pm, pc_mux_sel;
    logic [AW-1:0] jmp_loc;
    logic          ex_valid;
    logic [4:0]    ex_opcode, ex_rd, ex_rs1, ex_rs2;
    logic [7:0]    ex_imm;
    logic [AW-1:0] ex_pc;
    logic          halted;
    logic [15:0]   stall_cnt, flush_cnt;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        logic [4:0] op;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [7:0] imm;
        logic [7:0] pc;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_e;
    logic last_valid = 1'b0;
    logic prev_stall = 1'b0;

    logic [IW-1:0] mem [0:255];
    logic [AW-1:0] pc_r;

    ifid_hazard_unit #(.IW(IW), .AW(AW)) dut (
        .clk             (clk),
        .reset           (reset),
        .ins             (ins),
        .Current_Address (cur_addr),
        .ex_stall        (ex_stall),
        .Stall           (Stall),
        .Stall_pm        (Stall_pm),
        .pc_mux_sel      (pc_mux_sel),
        .jmp_loc         (jmp_loc),
        .ex_valid        (ex_valid),
        .ex_opcode       (ex_opcode),
        .ex_rd           (ex_rd),
        .ex_rs1          (ex_rs1),
        .ex_rs2          (ex_rs2),
        .ex_imm          (ex_imm),
        .ex_pc           (ex_pc),
        .halted          (halted),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    always #5 clk = ~clk;

    // Fetch stage + program memory: one-cycle read latency, PC holds on Stall,
    // output holds on Stall_pm, address muxed to jmp_loc on redirect.
    assign cur_addr = pc_mux_sel ? jmp_loc : pc_r;

    always @(posedge clk) begin
        if (reset) begin
            pc_r <= '0;
            ins  <= '0;
            cyc  <= 0;
        end else begin
            if (!Stall)
                pc_r <= cur_addr + 8'd1;
            if (!Stall_pm)
                ins <= mem[cur_addr];
            cyc <= cyc + 1;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic stall_val);
        @(posedge clk);
        #1 ex_stall = stall_val;
    endtask

    task automatic applyReset(input int n);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("reset_halted", halted, 0);
        checkOutput("reset_ex_valid", ex_valid, 0);
        checkOutput("reset_stall_cnt", stall_cnt, 0);
        checkOutput("reset_flush_cnt", flush_cnt, 0);
        repeat (n - 1) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic atCycle(input int k);
        int guard = 0;
        @(negedge clk);
        while (cyc != k && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != k) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL wait_cycle: got cycle %0d, expected cycle %0d", cyc, k);
        end
    endtask

    function automatic logic [IW-1:0] mkR(input logic [4:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2);
        return {op, rd, rs1, rs2, 4'h0};
    endfunction

    function automatic logic [IW-1:0] mkI(input logic [4:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [7:0] imm);
        return {op, rd, rs1, 1'b0, imm};
    endfunction

    // Architectural walk of the program: every non-JMP, non-HALT instruction on
    // the taken path enters EX exactly once, in program order.
    task automatic buildExpected();
        logic [7:0]    pc;
        logic [IW-1:0] w;
        exp_t          e;
        exp_q.delete();
        pc = 8'h00;
        for (int n = 0; n < 64; n++) begin
            w = mem[pc];
            if (w[23:19] == 5'h1F) break;
            if (w[23:19] == 5'h18) begin
                pc = w[7:0];
            end else begin
                e.op  = w[23:19];
                e.rd  = w[18:14];
                e.rs1 = w[13:9];
                e.rs2 = w[8:4];
                e.imm = w[7:0];
                e.pc  = pc;
                exp_q.push_back(e);
                pc = pc + 8'd1;
            end
        end
    endtask

    // Compare process: each new ID/EX load must be the next expected instruction;
    // a register held by backpressure must not change.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            checkOutput("rst_Stall", Stall, 0);
            checkOutput("rst_Stall_pm", Stall_pm, 0);
            checkOutput("rst_pc_mux_sel", pc_mux_sel, 0);
            checkOutput("rst_jmp_loc", jmp_loc, 0);
            prev_stall = 1'b0;
            last_valid = 1'b0;
        end else begin
            if (!prev_stall) begin
                if (ex_valid) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("ex_unexpected_pc", ex_pc, 'hFFFF);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("ex_pc", ex_pc, e.pc);
                        checkOutput("ex_opcode", ex_opcode, e.op);
                        checkOutput("ex_rd", ex_rd, e.rd);
                        checkOutput("ex_rs1", ex_rs1, e.rs1);
                        checkOutput("ex_rs2", ex_rs2, e.rs2);
                        checkOutput("ex_imm", ex_imm, e.imm);
                        last_e = e;
                    end
                end
                last_valid = ex_valid;
            end else begin
                checkOutput("frozen_ex_valid", ex_valid, last_valid);
                if (last_valid) begin
                    checkOutput("frozen_ex_pc", ex_pc, last_e.pc);
                    checkOutput("frozen_ex_opcode", ex_opcode, last_e.op);
                end
            end
            prev_stall = ex_stall;
        end
    end

    initial begin
        int exp_stall_a, exp_flush_a, exp_stall_b, exp_flush_b;
`ifdef IFID_PERF_CNT_EN
        exp_stall_a = 1; exp_flush_a = 1;
        exp_stall_b = 3; exp_flush_b = 1;
`else
        exp_stall_a = 0; exp_flush_a = 0;
        exp_stall_b = 0; exp_flush_b = 0;
`endif
        reset    = 1'b1;
        ex_stall = 1'b0;

        // Program A: load-use, rd=0 load, JMP to 0x40, HALT
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h00] = mkR(5'h01, 5'd1, 5'd2, 5'd3);
        mem[8'h01] = mkI(5'h10, 5'd3, 5'd1, 8'h00);
        mem[8'h02] = mkR(5'h01, 5'd4, 5'd3, 5'd5);
        mem[8'h03] = mkI(5'h10, 5'd0, 5'd2, 8'h00);
        mem[8'h04] = mkR(5'h01, 5'd6, 5'd0, 5'd0);
        mem[8'h05] = mkI(5'h18, 5'd0, 5'd0, 8'h40);
        mem[8'h06] = mkI(5'h08, 5'd7, 5'd1, 8'h05);
        mem[8'h40] = mkR(5'h01, 5'd8, 5'd1, 5'd2);
        mem[8'h41] = mkI(5'h1F, 5'd0, 5'd0, 8'h00);
        buildExpected();
        checkOutput("model_len_A", exp_q.size(), 6);
        applyReset(2);

        atCycle(0);
        checkOutput("boot_ex_valid", ex_valid, 0);
        checkOutput("boot_Stall", Stall, 0);
        checkOutput("boot_halted", halted, 0);
        atCycle(3);
        checkOutput("first_ex_valid", ex_valid, 1);
        checkOutput("first_ex_pc", ex_pc, 0);
        atCycle(4);
        checkOutput("lu_Stall", Stall, 1);
        checkOutput("lu_Stall_pm", Stall_pm, 1);
        atCycle(5);
        checkOutput("lu_bubble", ex_valid, 0);
        checkOutput("lu_Stall_once", Stall, 0);
        atCycle(6);
        checkOutput("lu_add_pc", ex_pc, 2);
        checkOutput("lu_add_rd", ex_rd, 4);
        atCycle(7);
        checkOutput("rd0_ld_in_ex", ex_opcode, 5'h10);
        checkOutput("rd0_no_stall", Stall, 0);
        atCycle(8);
        checkOutput("jmp_sel", pc_mux_sel, 1);
        checkOutput("jmp_loc", jmp_loc, 8'h40);
        checkOutput("jmp_no_stall", Stall, 0);
        atCycle(9);
        checkOutput("jmp_sel_once", pc_mux_sel, 0);
        checkOutput("jmp_bubble1", ex_valid, 0);
        atCycle(10);
        checkOutput("jmp_bubble2", ex_valid, 0);
        atCycle(11);
        checkOutput("target_ex_valid", ex_valid, 1);
        checkOutput("target_ex_pc", ex_pc, 8'h40);
        atCycle(12);
        checkOutput("halt_halted", halted, 1);
        checkOutput("halt_Stall", Stall, 1);
        checkOutput("halt_Stall_pm", Stall_pm, 1);
        checkOutput("halt_ex_valid", ex_valid, 0);
        atCycle(20);
        checkOutput("halt_held", halted, 1);
        checkOutput("halt_Stall_held", Stall, 1);
        checkOutput("stall_cnt_A", stall_cnt, exp_stall_a);
        checkOutput("flush_cnt_A", flush_cnt, exp_flush_a);
        checkOutput("queue_empty_A", exp_q.size(), 0);

        // Program B: JMP held in ID under 3 cycles of backpressure
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h00] = mkR(5'h01, 5'd1, 5'd2, 5'd3);
        mem[8'h01] = mkI(5'h18, 5'd0, 5'd0, 8'h20);
        mem[8'h02] = mkI(5'h08, 5'd7, 5'd1, 8'h05);
        mem[8'h20] = mkR(5'h01, 5'd9, 5'd1, 5'd1);
        mem[8'h21] = mkI(5'h1F, 5'd0, 5'd0, 8'h00);
        buildExpected();
        checkOutput("model_len_B", exp_q.size(), 2);
        applyReset(2);

        atCycle(0);
        checkOutput("rehalt_halted", halted, 0);
        checkOutput("rehalt_Stall", Stall, 0);
        atCycle(2);
        applyStimulus(1'b1);
        for (int k = 3; k <= 5; k++) begin
            atCycle(k);
            checkOutput("exs_Stall", Stall, 1);
            checkOutput("exs_pc_mux_sel", pc_mux_sel, 0);
            checkOutput("exs_ex_pc", ex_pc, 0);
        end
        applyStimulus(1'b0);
        atCycle(6);
        checkOutput("exs_redirect", pc_mux_sel, 1);
        checkOutput("exs_jmp_loc", jmp_loc, 8'h20);
        atCycle(7);
        checkOutput("exs_bubble", ex_valid, 0);
        atCycle(9);
        checkOutput("exs_target_pc", ex_pc, 8'h20);
        checkOutput("exs_target_valid", ex_valid, 1);
        atCycle(10);
        checkOutput("exs_halted", halted, 1);
        checkOutput("stall_cnt_B", stall_cnt, exp_stall_b);
        checkOutput("flush_cnt_B", flush_cnt, exp_flush_b);
        checkOutput("queue_empty_B", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
